// File: rtl/cache_ctrl_dm_if.sv
// Processor command bus and byte-wide backing-memory bus of the direct-mapped
// cache controller. The controller side uses the slave modport; the processor
// and memory environment uses the master modport.
interface cache_ctrl_dm_if #(
    parameter int TAG_W    = 6,
    parameter int INDEX_W  = 8,
    parameter int OFFSET_W = 2,
    parameter int DATA_W   = 8
);
    localparam int ADDR_W = TAG_W + INDEX_W + OFFSET_W;

    logic                proc_valid;
    logic                proc_read_n_write;
    logic [TAG_W-1:0]    proc_tag;
    logic [INDEX_W-1:0]  proc_index;
    logic [OFFSET_W-1:0] proc_bytesel;
    logic [DATA_W-1:0]   proc_wdata;
    logic                proc_stall;
    logic                proc_hit;
    logic                proc_miss;
    logic [DATA_W-1:0]   proc_rdata;
    logic                proc_rdata_valid;
    logic                cache_flush;

    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;
    logic                mem_ack;

    modport master (
        output proc_valid, proc_read_n_write, proc_tag, proc_index, proc_bytesel,
               proc_wdata, cache_flush, mem_rdata, mem_ack,
        input  proc_stall, proc_hit, proc_miss, proc_rdata, proc_rdata_valid,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  proc_valid, proc_read_n_write, proc_tag, proc_index, proc_bytesel,
               proc_wdata, cache_flush, mem_rdata, mem_ack,
        output proc_stall, proc_hit, proc_miss, proc_rdata, proc_rdata_valid,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_ctrl_dm.sv
// Direct-mapped, write-through, no-write-allocate cache controller.
// Read misses fill the whole line one byte per memory beat; writes always go
// to memory. Tag/data arrays are plain storage without reset; only the valid
// bits are cleared by reset or flush.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a command or a flush, stall low
// LOOKUP  | tag compare on the latched command, hit/miss pulse issued
// FILL    | fetching line beats 0..N-1 from memory after a read miss
// RESPOND | return the requested byte of the freshly filled line
// MEMWR   | write-through of one byte, waiting for the memory ack
module cache_ctrl_dm #(
    parameter int INDEX_W  = 8,
    parameter int TAG_W    = 6,
    parameter int OFFSET_W = 2,
    parameter int DATA_W   = 8
) (
    input  logic           clock,
    input  logic           reset,
    cache_ctrl_dm_if.slave bus
);
    localparam int ADDR_W = TAG_W + INDEX_W + OFFSET_W;
    localparam int LINES  = 1 << INDEX_W;
    localparam int BYTES  = 1 << OFFSET_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, FILL, RESPOND, MEMWR} state_t;

    state_t              state;
    logic                cmd_rnw;
    logic [TAG_W-1:0]    cmd_tag;
    logic [INDEX_W-1:0]  cmd_index;
    logic [OFFSET_W-1:0] cmd_bytesel;
    logic [DATA_W-1:0]   cmd_wdata;
    logic [OFFSET_W-1:0] beat;
    logic [OFFSET_W-1:0] next_beat;
    logic [LINES-1:0]    valid_bits;

    logic [TAG_W-1:0]    tag_array  [LINES];
    logic [DATA_W-1:0]   data_array [LINES][BYTES];

    logic                hit;
    logic                last_beat;
    logic                fill_ack;

    assign hit       = valid_bits[cmd_index] && (tag_array[cmd_index] == cmd_tag);
    assign last_beat = (beat == {OFFSET_W{1'b1}});
    assign next_beat = beat + 1'b1;
    assign fill_ack  = (state == FILL) && bus.mem_ack;

    // Sequencer: command acceptance, lookup, fill beats, write-through, registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state                <= IDLE;
            valid_bits           <= '0;
            cmd_rnw              <= 1'b0;
            cmd_tag              <= '0;
            cmd_index            <= '0;
            cmd_bytesel          <= '0;
            cmd_wdata            <= '0;
            beat                 <= '0;
            bus.proc_stall       <= 1'b0;
            bus.proc_hit         <= 1'b0;
            bus.proc_miss        <= 1'b0;
            bus.proc_rdata       <= '0;
            bus.proc_rdata_valid <= 1'b0;
            bus.mem_req          <= 1'b0;
            bus.mem_we           <= 1'b0;
            bus.mem_addr         <= '0;
            bus.mem_wdata        <= '0;
        end else begin
            bus.proc_hit         <= 1'b0;
            bus.proc_miss        <= 1'b0;
            bus.proc_rdata_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // Flush wins over a simultaneous command; that command is dropped.
                    if (bus.cache_flush) begin
                        valid_bits <= '0;
                    end else if (bus.proc_valid) begin
                        cmd_rnw        <= bus.proc_read_n_write;
                        cmd_tag        <= bus.proc_tag;
                        cmd_index      <= bus.proc_index;
                        cmd_bytesel    <= bus.proc_bytesel;
                        cmd_wdata      <= bus.proc_wdata;
                        state          <= LOOKUP;
                        bus.proc_stall <= 1'b1;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        bus.proc_hit <= 1'b1;
                    end else begin
                        bus.proc_miss <= 1'b1;
                    end
                    if (cmd_rnw && hit) begin
                        bus.proc_rdata       <= data_array[cmd_index][cmd_bytesel];
                        bus.proc_rdata_valid <= 1'b1;
                        bus.proc_stall       <= 1'b0;
                        state                <= IDLE;
                    end else if (cmd_rnw) begin
                        beat         <= '0;
                        bus.mem_req  <= 1'b1;
                        bus.mem_we   <= 1'b0;
                        bus.mem_addr <= {cmd_tag, cmd_index, {OFFSET_W{1'b0}}};
                        state        <= FILL;
                    end else begin
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= {cmd_tag, cmd_index, cmd_bytesel};
                        bus.mem_wdata <= cmd_wdata;
                        state         <= MEMWR;
                    end
                end
                FILL: begin
                    if (bus.mem_ack) begin
                        if (last_beat) begin
                            valid_bits[cmd_index] <= 1'b1;
                            bus.mem_req           <= 1'b0;
                            state                 <= RESPOND;
                        end else begin
                            beat         <= next_beat;
                            bus.mem_addr <= {cmd_tag, cmd_index, next_beat};
                        end
                    end
                end
                RESPOND: begin
                    bus.proc_rdata       <= data_array[cmd_index][cmd_bytesel];
                    bus.proc_rdata_valid <= 1'b1;
                    bus.proc_stall       <= 1'b0;
                    state                <= IDLE;
                end
                MEMWR: begin
                    if (bus.mem_ack) begin
                        bus.mem_req    <= 1'b0;
                        bus.mem_we     <= 1'b0;
                        bus.proc_stall <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: begin
                    bus.proc_stall <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

    // Tag/data storage: write-hit byte update and line fill; the old line is simply overwritten.
    always_ff @(posedge clock) begin
        if ((state == LOOKUP) && hit && !cmd_rnw) begin
            data_array[cmd_index][cmd_bytesel] <= cmd_wdata;
        end
        if (fill_ack) begin
            data_array[cmd_index][beat] <= bus.mem_rdata;
            if (last_beat) begin
                tag_array[cmd_index] <= cmd_tag;
            end
        end
    end
endmodule

// File: tb/tb_cache_ctrl_dm.sv
// Scoreboard bench for cache_ctrl_dm: stimulus pushes expected lookup results,
// read data and memory beats; monitors pop and compare when the DUT presents them.
module tb_cache_ctrl_dm;
    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } mem_exp_t;

    logic clock;
    logic reset;

    cache_ctrl_dm_if bus ();

    cache_ctrl_dm dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int       checks = 0;
    int       passes = 0;
    int       ack_delay = 0;
    int       beats_done = 0;
    bit       exp_look [$];
    logic [7:0] exp_read [$];
    mem_exp_t exp_mem [$];
    logic [7:0] mem_model [0:65535];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_mem(input logic we, input logic [15:0] addr, input logic [7:0] wdata);
        mem_exp_t e;
        e.we = we;
        e.addr = addr;
        e.wdata = wdata;
        exp_mem.push_back(e);
    endtask

    task automatic push_fill(input logic [15:0] base);
        for (int i = 0; i < 4; i++) begin
            push_mem(1'b0, base + 16'(i), 8'h00);
        end
    endtask

    task automatic drive_cmd(input bit rnw, input logic [5:0] tag, input logic [7:0] idx,
                             input logic [1:0] bs, input logic [7:0] wd);
        bus.proc_read_n_write = rnw;
        bus.proc_tag = tag;
        bus.proc_index = idx;
        bus.proc_bytesel = bs;
        bus.proc_wdata = wd;
        bus.proc_valid = 1'b1;
        @(negedge clock);
        bus.proc_valid = 1'b0;
    endtask

    task automatic issue(input bit rnw, input logic [5:0] tag, input logic [7:0] idx,
                         input logic [1:0] bs, input logic [7:0] wd,
                         input bit exp_hit, input logic [7:0] exp_rd, input int exp_stall);
        int n;
        exp_look.push_back(exp_hit);
        if (rnw) exp_read.push_back(exp_rd);
        drive_cmd(rnw, tag, idx, bs, wd);
        n = 0;
        while (bus.proc_stall === 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("stall_cycles", n, exp_stall);
    endtask

    // Backing memory: acks after ack_delay idle cycles, checks each beat against the scoreboard.
    initial begin
        int       wait_cnt;
        bit       held_ok;
        mem_exp_t e;
        logic [15:0] beat_addr;
        logic        beat_we;
        logic [7:0]  beat_wdata;
        wait_cnt = 0;
        held_ok = 1'b1;
        beat_addr = '0;
        beat_we = 1'b0;
        beat_wdata = '0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 8'h00;
        forever begin
            @(negedge clock);
            if (!reset) begin
                bus.mem_ack = 1'b0;
                wait_cnt = 0;
                held_ok = 1'b1;
            end else begin
                if (bus.mem_ack) begin
                    bus.mem_ack = 1'b0;
                    wait_cnt = 0;
                    held_ok = 1'b1;
                    beats_done++;
                end
                if (bus.mem_req) begin
                    if (wait_cnt == 0) begin
                        beat_addr = bus.mem_addr;
                        beat_we = bus.mem_we;
                        beat_wdata = bus.mem_wdata;
                    end else if (bus.mem_addr !== beat_addr || bus.mem_we !== beat_we ||
                                 (beat_we && bus.mem_wdata !== beat_wdata)) begin
                        held_ok = 1'b0;
                    end
                    if (wait_cnt == ack_delay) begin
                        bus.mem_ack = 1'b1;
                        bus.mem_rdata = mem_model[bus.mem_addr];
                        if (bus.mem_we) mem_model[bus.mem_addr] = bus.mem_wdata;
                        check("mem_beat_expected", 32'(exp_mem.size() != 0), 1);
                        if (exp_mem.size() != 0) begin
                            e = exp_mem.pop_front();
                            check("mem_we", 32'(bus.mem_we), 32'(e.we));
                            check("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
                            if (e.we) check("mem_wdata", 32'(bus.mem_wdata), 32'(e.wdata));
                            check("mem_held_stable", 32'(held_ok), 1);
                        end
                    end else begin
                        wait_cnt++;
                    end
                end
            end
        end
    end

    // Processor-side monitor: hit/miss pulses and read data against the scoreboard.
    initial begin
        bit         eh;
        logic [7:0] er;
        forever begin
            @(negedge clock);
            if (reset && (bus.proc_hit || bus.proc_miss)) begin
                check("hit_miss_exclusive", 32'(bus.proc_hit & bus.proc_miss), 0);
                check("lookup_expected", 32'(exp_look.size() != 0), 1);
                if (exp_look.size() != 0) begin
                    eh = exp_look.pop_front();
                    check("proc_hit", 32'(bus.proc_hit), 32'(eh));
                end
            end
            if (reset && bus.proc_rdata_valid) begin
                check("rdata_expected", 32'(exp_read.size() != 0), 1);
                if (exp_read.size() != 0) begin
                    er = exp_read.pop_front();
                    check("proc_rdata", 32'(bus.proc_rdata), 32'(er));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int start;
        for (int a = 0; a < 65536; a++) mem_model[a] = 8'hEE;
        for (int i = 0; i < 4; i++) begin
            mem_model[16'h4814 + i] = 8'h10 + 8'(i);
            mem_model[16'h0418 + i] = 8'h20 + 8'(i);
            mem_model[16'h4C14 + i] = 8'h30 + 8'(i);
        end
        reset = 1'b0;
        bus.proc_valid = 1'b0;
        bus.proc_read_n_write = 1'b1;
        bus.proc_tag = '0;
        bus.proc_index = '0;
        bus.proc_bytesel = '0;
        bus.proc_wdata = '0;
        bus.cache_flush = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_stall", 32'(bus.proc_stall), 0);
        check("rst_hit", 32'(bus.proc_hit), 0);
        check("rst_miss", 32'(bus.proc_miss), 0);
        check("rst_rdata_valid", 32'(bus.proc_rdata_valid), 0);
        check("rst_rdata", 32'(bus.proc_rdata), 0);
        check("rst_mem_req", 32'(bus.mem_req), 0);
        check("rst_mem_we", 32'(bus.mem_we), 0);
        check("rst_mem_addr", 32'(bus.mem_addr), 0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 0);
        reset = 1'b1;
        @(negedge clock);

        // Cold read miss, fill, then hit on the same byte.
        ack_delay = 0;
        push_fill(16'h4814);
        issue(1, 6'h12, 8'h05, 2'd2, 8'h00, 0, 8'h12, 6);
        issue(1, 6'h12, 8'h05, 2'd2, 8'h00, 1, 8'h12, 1);

        // Write hit with slow memory, then read back the updated byte.
        ack_delay = 3;
        push_mem(1, 16'h4814, 8'hA5);
        issue(0, 6'h12, 8'h05, 2'd0, 8'hA5, 1, 8'h00, 5);
        ack_delay = 0;
        issue(1, 6'h12, 8'h05, 2'd0, 8'h00, 1, 8'hA5, 1);

        // Write miss without allocate; the following read fills from written memory.
        push_mem(1, 16'h0418, 8'h3C);
        issue(0, 6'h01, 8'h06, 2'd0, 8'h3C, 0, 8'h00, 2);
        push_fill(16'h0418);
        issue(1, 6'h01, 8'h06, 2'd0, 8'h00, 0, 8'h3C, 6);

        // Conflict on index 5 between tags 0x12 and 0x13.
        push_fill(16'h4C14);
        issue(1, 6'h13, 8'h05, 2'd1, 8'h00, 0, 8'h31, 6);
        push_fill(16'h4814);
        issue(1, 6'h12, 8'h05, 2'd0, 8'h00, 0, 8'hA5, 6);
        push_fill(16'h4C14);
        issue(1, 6'h13, 8'h05, 2'd3, 8'h00, 0, 8'h33, 6);
        issue(1, 6'h13, 8'h05, 2'd2, 8'h00, 1, 8'h32, 1);

        // Flush with a simultaneous command: the command must be dropped.
        bus.cache_flush = 1'b1;
        drive_cmd(1, 6'h13, 8'h05, 2'd2, 8'h00);
        bus.cache_flush = 1'b0;
        check("flush_no_accept_stall", 32'(bus.proc_stall), 0);
        push_fill(16'h4C14);
        issue(1, 6'h13, 8'h05, 2'd2, 8'h00, 0, 8'h32, 6);
        push_fill(16'h0418);
        issue(1, 6'h01, 8'h06, 2'd1, 8'h00, 0, 8'h21, 6);

        // Back-to-back hits, one command every two cycles.
        issue(1, 6'h13, 8'h05, 2'd0, 8'h00, 1, 8'h30, 1);
        issue(1, 6'h13, 8'h05, 2'd1, 8'h00, 1, 8'h31, 1);

        // Reset after two fill beats abandons the line.
        ack_delay = 2;
        exp_look.push_back(1'b0);
        push_mem(0, 16'h4814, 8'h00);
        push_mem(0, 16'h4815, 8'h00);
        start = beats_done;
        drive_cmd(1, 6'h12, 8'h05, 2'd1, 8'h00);
        n = 0;
        while ((beats_done - start) < 2 && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("fill_beats_before_reset", 32'(beats_done - start), 2);
        #2;
        reset = 1'b0;
        #1;
        check("midfill_rst_mem_req", 32'(bus.mem_req), 0);
        check("midfill_rst_stall", 32'(bus.proc_stall), 0);
        check("midfill_no_pending_beats", 32'(exp_mem.size()), 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        ack_delay = 0;
        @(negedge clock);
        push_fill(16'h4814);
        issue(1, 6'h12, 8'h05, 2'd1, 8'h00, 0, 8'h11, 6);
        push_fill(16'h0418);
        issue(1, 6'h01, 8'h06, 2'd2, 8'h00, 0, 8'h22, 6);

        repeat (5) @(negedge clock);
        check("drain_lookup", 32'(exp_look.size()), 0);
        check("drain_rdata", 32'(exp_read.size()), 0);
        check("drain_mem", 32'(exp_mem.size()), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
